// File: rtl/operation_unit_seq_pkg.sv
// Shared definitions for the accumulator/ALU execution unit.
//   - opcode encodings (4-bit op field driven by the control unit)
//   - FSM state encoding for the multi-cycle sequencer
//   - small decode helper
package operation_unit_seq_pkg;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADC  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_CLC  = 4'd11;
  // 12..15 are NOPs

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/operation_unit_seq_if.sv
// Control/data bus between the control unit and the execution unit.
//   master : control side (drives start/op/acc_sel/in_b, observes status)
//   slave  : execution unit (drives busy/done/result/mul_hi/cy/z)
interface operation_unit_seq_if #(
  parameter int WIDTH = 8,
  parameter int NACC  = 4
);
  localparam int ASEL_W = (NACC > 1) ? $clog2(NACC) : 1;

  logic              start;
  logic [3:0]        op;
  logic [ASEL_W-1:0] acc_sel;
  logic [WIDTH-1:0]  in_b;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  mul_hi;
  logic              cy;
  logic              z;

  modport master (
    output start, op, acc_sel, in_b,
    input  busy, done, result, mul_hi, cy, z
  );

  modport slave (
    input  start, op, acc_sel, in_b,
    output busy, done, result, mul_hi, cy, z
  );

endinterface

// File: rtl/operation_unit_seq_alu.sv
// alu_comb: purely combinational single-cycle operations.
//   a, b   : accumulator value and bus operand
//   op     : opcode
//   cy_in  : current carry flag
//   res    : value to write back to the accumulator
//   cy_out : next carry flag (cy_in when the op leaves it alone)
//   we     : accumulator (and zero flag) write enable
// Shift opcodes only arrive here with a zero count, so they pass A through.
module alu_comb
  import operation_unit_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             cy_in,
  output logic [WIDTH-1:0] res,
  output logic             cy_out,
  output logic             we
);

  logic [WIDTH:0] sum;

  always_comb begin
    res    = a;
    cy_out = cy_in;
    we     = 1'b1;
    sum    = '0;
    case (op)
      OP_LOAD: res = b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        res    = sum[WIDTH-1:0];
        cy_out = sum[WIDTH];
      end
      OP_ADC: begin
        sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cy_in};
        res    = sum[WIDTH-1:0];
        cy_out = sum[WIDTH];
      end
      OP_SUB: begin
        // bit WIDTH of the extended difference is the borrow (a < b)
        sum    = {1'b0, a} - {1'b0, b};
        res    = sum[WIDTH-1:0];
        cy_out = sum[WIDTH];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL, OP_SHR: res = a;
      OP_CLC: begin
        cy_out = 1'b0;
        we     = 1'b0;
      end
      default: we = 1'b0;  // MUL (never committed here) and NOPs
    endcase
  end

endmodule

// File: rtl/operation_unit_seq.sv
// operation_unit_seq: NACC-accumulator execution unit with shared CY/Z flags.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of operation_unit_seq_if
//              start/op/acc_sel/in_b in; busy/done/result/mul_hi/cy/z out
// Single-cycle ops commit on the accepting edge. SHL/SHR (count >= 1) and MUL
// run in work registers one step per edge and write the accumulator only on
// the final step, so partial values are never visible through result.
module operation_unit_seq
  import operation_unit_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NACC  = 4
) (
  input  logic                clk,
  input  logic                rst,
  operation_unit_seq_if.slave bus
);

  localparam int ASEL_W = (NACC > 1) ? $clog2(NACC) : 1;
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WMAX = WIDTH[WIDTH-1:0];

  logic [NACC-1:0][WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]  mul_hi_q;
  logic              cy_q, z_q, done_q;

  state_e            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [WIDTH-1:0]  wk_q, wk_nxt;     // shift value / multiplier low half
  logic [WIDTH-1:0]  hi_q, hi_nxt;     // product high half
  logic [WIDTH-1:0]  b_q, b_nxt;       // latched multiplicand
  logic              shl_q, shl_nxt;   // shift direction
  logic [ASEL_W-1:0] sel_q, sel_nxt;   // target accumulator of op in flight

  logic              acc_we, cy_we, z_we, mh_we, commit;
  logic [ASEL_W-1:0] acc_idx;
  logic [WIDTH-1:0]  acc_wd, mh_wd;
  logic              cy_wd;

  logic [WIDTH-1:0]  acc_rd;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_cy, alu_we;
  logic              accept, bit_out;
  logic [WIDTH-1:0]  n_full;
  logic [CNT_W-1:0]  n_cnt;
  logic [WIDTH:0]    madd;
  logic [2*WIDTH:0]  mstep;

  // Read mux follows the live acc_sel; out-of-range selects read zero.
  always_comb begin
    acc_rd = '0;
    for (int i = 0; i < NACC; i++)
      if (bus.acc_sel == ASEL_W'(i)) acc_rd = acc_q[i];
  end

  alu_comb #(.WIDTH(WIDTH)) u_alu (
    .a      (acc_rd),
    .b      (bus.in_b),
    .op     (bus.op),
    .cy_in  (cy_q),
    .res    (alu_res),
    .cy_out (alu_cy),
    .we     (alu_we)
  );

  assign accept = bus.start && (state_q == S_IDLE);
  assign n_full = (bus.in_b > WMAX) ? WMAX : bus.in_b;
  assign n_cnt  = n_full[CNT_W-1:0];

  // One shift-add step: add multiplicand if the multiplier LSB is set, then
  // shift {carry, hi, lo} right; lo gradually fills with product bits.
  assign madd  = {1'b0, hi_q} + (wk_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  assign mstep = {madd, wk_q};
  assign bit_out = shl_q ? wk_q[WIDTH-1] : wk_q[0];

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    wk_nxt    = wk_q;
    hi_nxt    = hi_q;
    b_nxt     = b_q;
    shl_nxt   = shl_q;
    sel_nxt   = sel_q;
    commit    = 1'b0;
    acc_we    = 1'b0;
    acc_idx   = sel_q;
    acc_wd    = wk_q;
    cy_we     = 1'b0;
    cy_wd     = cy_q;
    z_we      = 1'b0;
    mh_we     = 1'b0;
    mh_wd     = hi_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sel_nxt = bus.acc_sel;
          b_nxt   = bus.in_b;
          wk_nxt  = acc_rd;
          if (is_shift(bus.op) && (n_cnt != '0)) begin
            state_nxt = S_SHIFT;
            cnt_nxt   = n_cnt;
            shl_nxt   = (bus.op == OP_SHL);
          end else if (bus.op == OP_MUL) begin
            state_nxt = S_MUL;
            cnt_nxt   = CNT_W'(WIDTH);
            hi_nxt    = '0;
          end else begin
            commit  = 1'b1;
            acc_we  = alu_we;
            acc_idx = bus.acc_sel;
            acc_wd  = alu_res;
            z_we    = alu_we;
            cy_we   = 1'b1;
            cy_wd   = alu_cy;
          end
        end
      end
      S_SHIFT: begin
        wk_nxt  = shl_q ? (wk_q << 1) : (wk_q >> 1);
        cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_nxt = S_IDLE;
          commit    = 1'b1;
          acc_we    = 1'b1;
          acc_wd    = wk_nxt;
          z_we      = 1'b1;
          cy_we     = 1'b1;
          cy_wd     = bit_out;
        end
      end
      S_MUL: begin
        hi_nxt  = mstep[2*WIDTH:WIDTH+1];
        wk_nxt  = mstep[WIDTH:1];
        cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_nxt = S_IDLE;
          commit    = 1'b1;
          acc_we    = 1'b1;
          acc_wd    = wk_nxt;
          z_we      = 1'b1;
          cy_we     = 1'b1;
          cy_wd     = 1'b0;
          mh_we     = 1'b1;
          mh_wd     = hi_nxt;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mul_hi_q <= '0;
      cy_q     <= 1'b0;
      z_q      <= 1'b1;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      wk_q     <= '0;
      hi_q     <= '0;
      b_q      <= '0;
      shl_q    <= 1'b0;
      sel_q    <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      wk_q    <= wk_nxt;
      hi_q    <= hi_nxt;
      b_q     <= b_nxt;
      shl_q   <= shl_nxt;
      sel_q   <= sel_nxt;
      done_q  <= commit;
      for (int i = 0; i < NACC; i++)
        if (acc_we && (acc_idx == ASEL_W'(i))) acc_q[i] <= acc_wd;
      if (z_we)  z_q      <= (acc_wd == '0);
      if (cy_we) cy_q     <= cy_wd;
      if (mh_we) mul_hi_q <= mh_wd;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = acc_rd;
  assign bus.mul_hi = mul_hi_q;
  assign bus.cy     = cy_q;
  assign bus.z      = z_q;

endmodule
